cruise_cmd_sequencer: RTL
=========================

Name: cruise_cmd_sequencer

Overview:
- Front-end controller for the `cruise` module.
- Turns raw, bouncy driver button levels into clean single-cycle command pulses for the `cruise` inputs `set`, `accel`, `coast`, `cancel`, `resume` and `brake`.
- Debounces each button, arbitrates simultaneous presses by fixed priority, and gates commands on cruise state.
- Generates auto-repeat for held accel/coast and enforces a post-brake lockout window.

Parameters:
- DEB_CYC, 3: consecutive high samples required before a button counts as pressed (≥1).
- REP_DLY, 20: cycles from the first accel/coast pulse to the first auto-repeat pulse (≥2).
- REP_PER, 5: cycles between subsequent auto-repeat pulses (≥2).
- LOCK_CYC, 8: lockout length in cycles after brake release (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_set  in  1  raw set button level.
- btn_accel  in  1  raw accel button level.
- btn_coast  in  1  raw coast button level.
- btn_cancel  in  1  raw cancel button level.
- btn_resume  in  1  raw resume button level.
- brake_in  in  1  raw brake pedal switch, not debounced.
- cruisecontrol  in  1  engaged status from the `cruise` module.
- set  out  1  one-cycle set command.
- accel  out  1  one-cycle accel command.
- coast  out  1  one-cycle coast command.
- cancel  out  1  one-cycle cancel command.
- resume  out  1  one-cycle resume command.
- brake  out  1  registered brake level to `cruise`.
- lockout  out  1  high while post-brake lockout is active.

Behaviour:
- Reset (sync, active-high):
  - All outputs 0; all debounce counters, repeat timer and lockout counter 0; debounced levels low.
  - Reset mid-operation aborts any repeat.
  - A button held through reset must re-debounce from zero, then fires normally, because its debounced level was cleared.
- Debounce (per button):
  - Counter increments while raw is high and saturates at DEB_CYC; it is cleared at any edge where raw is sampled low.
  - The debounced level is high while the counter equals DEB_CYC.
  - A press event is the rising edge of the debounced level.
  - Latency: raw sampled high at edges n..n+DEB_CYC-1 gives a pulse registered at edge n+DEB_CYC, high for exactly one cycle.
- Brake path:
  - `brake` = `brake_in` delayed one edge, level, no debounce.
  - While `brake_in` is sampled high, the lockout counter loads LOCK_CYC.
  - Otherwise the counter decrements to 0 and stops.
  - `lockout` = (counter != 0).
- Gating, evaluated at the same edge as the event:
  - cancel: always allowed, including during lockout and during brake.
  - set: blocked when lockout = 1 or `brake_in` = 1.
  - resume: blocked when lockout = 1, `brake_in` = 1, or cruisecontrol = 1.
  - accel/coast: blocked when lockout = 1, `brake_in` = 1, or cruisecontrol = 0.
  - Blocked events are discarded, not deferred. A button held past the end of lockout does not fire until it is released and re-pressed.
- Arbitration:
  - At most one of set/accel/coast/cancel/resume is high per cycle.
  - Priority: cancel > set > resume > accel > coast.
  - Losing events in the same cycle are dropped.
- Auto-repeat (accel/coast only):
  - After an accel pulse at edge p, while btn_accel stays debounced high and gating allows, further pulses occur at p+REP_DLY, then every REP_PER cycles. Coast behaves the same way.
  - Release stops the repeat immediately.
  - Repeat pulses obey gating and priority. A dropped repeat pulse does not shift the schedule.
  - If accel and coast are both debounced high, neither issues press or repeat pulses until one is released; the remaining one must then be re-pressed.
  - Any pulse that loses to cancel/set/resume cancels the repeat.
- Implementation notes:
  - Repeat timer width covers max(REP_DLY, REP_PER).
  - Debounce counter width is clog2(DEB_CYC+1).
  - All counters saturate; none wrap.

Test Plan (defaults: DEB_CYC=3, REP_DLY=20, REP_PER=5, LOCK_CYC=8):
- Debounce: btn_set high 2 cycles, then low, then high from edge 10 → no pulse for the short press; set=1 for the single cycle after edge 13 only.
- Auto-repeat: cruisecontrol=1, btn_accel high at edges 0..39 → accel pulses at edges 3, 23, 28, 33, 38; none after release. Same stimulus with cruisecontrol=0 → no pulses.
- Brake lockout: brake_in high for edge 50 only → brake=1 after edge 50; lockout high edges 50..57, low from 58. btn_resume pressed at 52 and held to 70 → no resume pulse. Re-press at 80 → resume after edge 83.
- Priority: btn_cancel and btn_set rise together → cancel pulse only; set never asserts for that press.
- Accel/coast conflict: both held with cruisecontrol=1 → no pulses. Release coast, re-press accel → accel pulse 3 edges after re-press.
- Reset mid-repeat: accel repeating, reset high one cycle → all outputs 0 next edge. Accel still held → fresh pulse DEB_CYC edges after reset deasserts, next repeat REP_DLY later.

Source files
------------

// File: rtl/cruise_cmd_sequencer.sv
// Front-end for the cruise module: debounces driver buttons, arbitrates and gates
// them into single-cycle commands, auto-repeats accel/coast and applies post-brake lockout.
module cruise_cmd_sequencer #(
  parameter int unsigned DEB_CYC  = 3,
  parameter int unsigned REP_DLY  = 20,
  parameter int unsigned REP_PER  = 5,
  parameter int unsigned LOCK_CYC = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_accel,
  input  logic btn_coast,
  input  logic btn_cancel,
  input  logic btn_resume,
  input  logic brake_in,
  input  logic cruisecontrol,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic lockout
);

  localparam int unsigned NB      = 5;
  localparam int unsigned B_SET   = 0;
  localparam int unsigned B_ACCEL = 1;
  localparam int unsigned B_COAST = 2;
  localparam int unsigned B_CANC  = 3;
  localparam int unsigned B_RES   = 4;
  localparam int unsigned DW      = $clog2(DEB_CYC + 1);
  localparam int unsigned REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned TW      = $clog2(REP_MAX + 1);
  localparam int unsigned LW      = $clog2(LOCK_CYC + 1);

  typedef enum logic [1:0] {REP_IDLE, REP_ACCEL, REP_COAST} rep_t;

  logic [NB-1:0] raw, deb, deb_q, ev;
  logic [DW-1:0] dcnt [NB];
  logic [LW-1:0] lcnt;
  logic [TW-1:0] tmr, tmr_n;
  rep_t          state, state_n;
  logic          blk, conflict, ac_ok, rep_hold, rep_due;
  logic          set_req, resume_req, accel_req, coast_req, hi_req;
  logic          set_n, accel_n, coast_n, cancel_n, resume_n;

  assign raw = {btn_resume, btn_cancel, btn_coast, btn_accel, btn_set};

  always_comb begin
    deb = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      deb[i] = (dcnt[i] == DW'(DEB_CYC));
    end
  end

  assign ev         = deb & ~deb_q;
  assign lockout    = (lcnt != '0);
  assign blk        = lockout | brake_in;
  assign conflict   = deb[B_ACCEL] & deb[B_COAST];
  assign ac_ok      = ~blk & cruisecontrol & ~conflict;
  assign rep_hold   = (((state == REP_ACCEL) & deb[B_ACCEL]) |
                       ((state == REP_COAST) & deb[B_COAST])) & ~conflict;
  assign rep_due    = rep_hold & (tmr == TW'(1));
  assign set_req    = ev[B_SET] & ~blk;
  assign resume_req = ev[B_RES] & ~blk & ~cruisecontrol;
  assign accel_req  = (ev[B_ACCEL] | (rep_due & (state == REP_ACCEL))) & ac_ok;
  assign coast_req  = (ev[B_COAST] | (rep_due & (state == REP_COAST))) & ac_ok;
  assign hi_req     = ev[B_CANC] | set_req | resume_req;

  always_comb begin
    set_n    = 1'b0;
    accel_n  = 1'b0;
    coast_n  = 1'b0;
    cancel_n = 1'b0;
    resume_n = 1'b0;
    state_n  = state;
    tmr_n    = tmr;
    if (ev[B_CANC])     cancel_n = 1'b1;
    else if (set_req)    set_n    = 1'b1;
    else if (resume_req) resume_n = 1'b1;
    else if (accel_req)  accel_n  = 1'b1;
    else if (coast_req)  coast_n  = 1'b1;

    // A due repeat reloads the period even when gating drops the pulse itself
    if (state != REP_IDLE) begin
      if (!rep_hold) begin
        state_n = REP_IDLE;
        tmr_n   = '0;
      end else if (tmr == TW'(1)) begin
        tmr_n = TW'(REP_PER);
      end else if (tmr != '0) begin
        tmr_n = tmr - 1'b1;
      end
    end

    if ((accel_req | coast_req) & hi_req) begin
      state_n = REP_IDLE;
      tmr_n   = '0;
    end else if (accel_n & ev[B_ACCEL]) begin
      state_n = REP_ACCEL;
      tmr_n   = TW'(REP_DLY);
    end else if (coast_n & ev[B_COAST]) begin
      state_n = REP_COAST;
      tmr_n   = TW'(REP_DLY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NB; i++) dcnt[i] <= '0;
      deb_q  <= '0;
      lcnt   <= '0;
      brake  <= 1'b0;
      state  <= REP_IDLE;
      tmr    <= '0;
      set    <= 1'b0;
      accel  <= 1'b0;
      coast  <= 1'b0;
      cancel <= 1'b0;
      resume <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (!raw[i])                     dcnt[i] <= '0;
        else if (dcnt[i] != DW'(DEB_CYC)) dcnt[i] <= dcnt[i] + 1'b1;
      end
      deb_q <= deb;
      brake <= brake_in;
      if (brake_in)          lcnt <= LW'(LOCK_CYC);
      else if (lcnt != '0)   lcnt <= lcnt - 1'b1;
      state  <= state_n;
      tmr    <= tmr_n;
      set    <= set_n;
      accel  <= accel_n;
      coast  <= coast_n;
      cancel <= cancel_n;
      resume <= resume_n;
    end
  end

endmodule
